// File: rtl/carry_resolve_adder_pkg.sv
// Shared definitions for the carry-resolve adder.
//   state_e    : control FSM encoding (IDLE/RUN/DONE; the fourth code is illegal
//                and recovers to IDLE)
//   cnt_w_for  : smallest iteration-counter width that can hold 0..N+1
package carry_resolve_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  // The resolve loop uses at most N+1 passes, so the counter must hold N+1.
  function automatic int cnt_w_for(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/cr_half_cell.sv
// One-bit half adder used as a single bit slice of a carry-resolve pass.
//   x_i, y_i : operand bits
//   so_o     : x_i ^ y_i
//   co_o     : x_i & y_i
module cr_half_cell (
  input  logic x_i,
  input  logic y_i,
  output logic so_o,
  output logic co_o
);

  assign so_o = x_i ^ y_i;
  assign co_o = x_i & y_i;

endmodule

// File: rtl/carry_resolve_adder.sv
// Resolves the per-bit sum/carry vectors of an N-wide half-adder array into the
// true (N+1)-bit sum by repeated half-adder passes (s' = s^c, c' = (s&c)<<1)
// until no carry remains. One operand is processed at a time.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE and the
// result/iter_count/incons outputs are held stable until out_ready is seen.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset (priority over all)
//   in_valid    : sum_in/cout_in valid         in_ready  : accepting (IDLE)
//   sum_in      : per-bit sum  (weight 2^i)    cout_in   : per-bit carry (weight 2^(i+1))
//   out_valid   : result valid (DONE)          out_ready : consumer takes result
//   result      : resolved a+b, N+1 bits       iter_count: passes used (0..N+1)
//   incons      : input had a bit set in both sum_in and cout_in
//   state_dbg   : current FSM state
module carry_resolve_adder
  import carry_resolve_adder_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = cnt_w_for(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     sum_in,
  input  logic [N-1:0]     cout_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N:0]       result,
  output logic [CNT_W-1:0] iter_count,
  output logic             incons,
  output state_e           state_dbg
);

  state_e           state_q, state_d;
  logic [N:0]       s_q, s_d;
  logic [N:0]       c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             incons_q, incons_d;

  // One resolve pass across all N+1 bit positions.
  logic [N:0] pass_s;
  logic [N:0] pass_c;

  for (genvar i = 0; i <= N; i++) begin : g_cell
    cr_half_cell u_cell (
      .x_i  (s_q[i]),
      .y_i  (c_q[i]),
      .so_o (pass_s[i]),
      .co_o (pass_c[i])
    );
  end

  // Carries move up one weight; a carry out of bit N is dropped (mod 2^(N+1)).
  logic [N:0] c_shift;
  assign c_shift = {pass_c[N-1:0], 1'b0};

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    incons_d = incons_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          s_d      = {1'b0, sum_in};
          c_d      = {cout_in, 1'b0};
          cnt_d    = '0;
          incons_d = |(sum_in & cout_in);
          state_d  = (cout_in == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        s_d   = pass_s;
        c_d   = c_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (c_shift == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        // A concurrent in_valid is not looked at here; it waits for IDLE.
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      incons_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      incons_q <= incons_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign result     = s_q;
  assign iter_count = cnt_q;
  assign incons     = incons_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_carry_resolve_adder.sv
// Directed bench for carry_resolve_adder (N=4).
module tb_carry_resolve_adder;
  import carry_resolve_adder_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = 3;
  localparam int WAIT_BUDGET = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [N-1:0]     sum_in    = '0;
  logic [N-1:0]     cout_in   = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N:0]       result;
  logic [CNT_W-1:0] iter_count;
  logic             incons;
  state_e           state_dbg;

  carry_resolve_adder #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum_in     (sum_in),
    .cout_in    (cout_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .iter_count (iter_count),
    .incons     (incons),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [N:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand, return edges from the accept edge to first out_valid.
  task automatic send_op(input string tag, input logic [N-1:0] s, input logic [N-1:0] c,
                         output int lat);
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
    sum_in   = s;
    cout_in  = c;
    in_valid = 1'b1;
    tick();                 // accept edge
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < WAIT_BUDGET) begin
      tick();
      lat++;
    end
    check_eq({tag, " out_valid"}, 32'(out_valid), 32'd1);
  endtask

  // Take the result, check it against the queue head, confirm return to IDLE.
  task automatic take_result(input string tag);
    logic [N:0] exp;
    exp = exp_q.pop_front();
    check_eq({tag, " result"}, 32'(result), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check_eq({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int max_iter;

    // Reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst in_ready", 32'(in_ready), 32'd1);
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst result", 32'(result), 32'd0);
    check_eq("rst iter_count", 32'(iter_count), 32'd0);
    check_eq("rst incons", 32'(incons), 32'd0);
    check_eq("rst state", 32'(state_dbg), 32'(ST_IDLE));

    // T1: 0+0 -> no carries, DONE right after accept
    exp_q.push_back(5'h00);
    send_op("T1", 4'h0, 4'h0, lat);
    check_eq("T1 latency", 32'(lat), 32'd1);
    check_eq("T1 iter_count", 32'(iter_count), 32'd0);
    check_eq("T1 incons", 32'(incons), 32'd0);
    take_result("T1");

    // T2: 5+3 -> sum 0x6, carry 0x1; three passes
    exp_q.push_back(5'h08);
    send_op("T2", 4'h6, 4'h1, lat);
    check_eq("T2 latency", 32'(lat), 32'd4);
    check_eq("T2 iter_count", 32'(iter_count), 32'd3);
    take_result("T2");

    // T3: F+1 -> carry ripples out into bit 4; four passes
    exp_q.push_back(5'h10);
    send_op("T3", 4'hE, 4'h1, lat);
    check_eq("T3 latency", 32'(lat), 32'd5);
    check_eq("T3 iter_count", 32'(iter_count), 32'd4);
    take_result("T3");

    // T4: back-pressure on T2; a new operand offered during DONE is ignored
    send_op("T4", 4'h6, 4'h1, lat);
    sum_in   = 4'hF;
    cout_in  = 4'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("T4 hold out_valid", 32'(out_valid), 32'd1);
      check_eq("T4 hold result", 32'(result), 32'h08);
      check_eq("T4 hold iter", 32'(iter_count), 32'd3);
      check_eq("T4 hold in_ready", 32'(in_ready), 32'd0);
    end
    // out_ready and in_valid together in DONE: only the output is taken
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("T4 state idle", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("T4 result kept", 32'(result), 32'h08);
    check_eq("T4 iter kept", 32'(iter_count), 32'd3);
    tick();
    check_eq("T4 no capture", 32'(state_dbg), 32'(ST_IDLE));

    // T5: reset two cycles after accepting T3
    sum_in   = 4'hE;
    cout_in  = 4'h1;
    in_valid = 1'b1;
    tick();                 // accept edge
    in_valid = 1'b0;
    check_eq("T5 running", 32'(state_dbg), 32'(ST_RUN));
    tick();
    check_eq("T5 no valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("T5 abort valid", 32'(out_valid), 32'd0);
    check_eq("T5 abort state", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("T5 abort in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(5'h08);
    send_op("T5b", 4'h6, 4'h1, lat);
    check_eq("T5b iter_count", 32'(iter_count), 32'd3);
    take_result("T5b");

    // T6: inconsistent pair 0x1/0x1: s=0x01, c=0x02 -> one pass gives 0x03
    exp_q.push_back(5'h03);
    send_op("T6", 4'h1, 4'h1, lat);
    check_eq("T6 incons", 32'(incons), 32'd1);
    check_eq("T6 iter_count", 32'(iter_count), 32'd1);
    check_eq("T6 latency", 32'(lat), 32'd2);
    take_result("T6");

    // Sweep all a,b pairs through an ideal half-adder array
    max_iter = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [N-1:0] av, bv;
        av = N'(a);
        bv = N'(b);
        exp_q.push_back(5'(a + b));
        send_op("SW", av ^ bv, av & bv, lat);
        check_eq("SW incons", 32'(incons), 32'd0);
        check_eq("SW latency", 32'(lat), 32'(iter_count) + 32'd1);
        if (int'(iter_count) > max_iter) max_iter = int'(iter_count);
        take_result("SW");
      end
    end
    check_eq("SW max iter <= 5", 32'(max_iter <= 5), 32'd1);
    check_eq("SW queue empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
